// File: rtl/qtcore_spi_frontend.sv
// SPI-style front end between the chip pins and NUM_CHAINS qtcore cores.
// A command header selects scan streaming of one core, a halt-status
// snapshot read, a run-mask write, or a discard. Between transactions
// proc_en_n runs every unmasked core and miso reports their halt status.
module qtcore_spi_frontend #(
    parameter int NUM_CHAINS = 4,
    parameter int CMD_BITS   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic                  proc_en_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [NUM_CHAINS-1:0] chain_scan_enable,
    output logic                  chain_scan_in,
    input  logic [NUM_CHAINS-1:0] chain_scan_out,
    input  logic [NUM_CHAINS-1:0] halt_in,
    output logic [NUM_CHAINS-1:0] proc_en,
    output logic [CNT_W-1:0]      stream_count,
    output logic                  busy
);

    localparam int IDX_W  = (CMD_BITS > 2) ? CMD_BITS - 2 : 1;
    localparam int HCNT_W = $clog2(CMD_BITS + 1);
    localparam int MCNT_W = $clog2(NUM_CHAINS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_STREAM  = 3'd2,
        S_STATUS  = 3'd3,
        S_MASKWR  = 3'd4,
        S_DISCARD = 3'd5
    } state_t;

    // The header index field must be able to address the highest core.
    if (CMD_BITS < 3 || NUM_CHAINS < 1 || (NUM_CHAINS - 1) >= (1 << IDX_W)) begin : g_bad_params
        $error("qtcore_spi_frontend: CMD_BITS index field cannot address NUM_CHAINS-1");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_busy;
    logic [CMD_BITS-1:0]   r_hdr;
    logic [HCNT_W-1:0]     r_hdr_cnt;
    logic [IDX_W-1:0]      r_sel;
    logic [NUM_CHAINS-1:0] r_stat_sr;
    logic [NUM_CHAINS-1:0] r_mask_sr;
    logic [MCNT_W-1:0]     r_mask_cnt;
    logic [NUM_CHAINS-1:0] r_run_mask;
    logic [CNT_W-1:0]      r_stream_cnt;

    logic [CMD_BITS-1:0]   w_hdr_next;
    logic [NUM_CHAINS-1:0] w_mask_next;
    logic [NUM_CHAINS-1:0] w_stat_shift;
    logic [1:0]            w_opcode;
    logic [IDX_W-1:0]      w_index;
    logic                  w_index_ok;
    logic                  w_hdr_last;
    logic [NUM_CHAINS-1:0] w_sel_onehot;
    logic                  w_sel_scan_out;

    // Shift-register next values and header field decode.
    always_comb begin
        w_hdr_next      = r_hdr << 1;
        w_hdr_next[0]   = mosi;
        w_mask_next     = r_mask_sr << 1;
        w_mask_next[0]  = mosi;
        w_stat_shift    = r_stat_sr << 1;
        w_opcode        = w_hdr_next[CMD_BITS-1 -: 2];
        w_index         = w_hdr_next[IDX_W-1:0];
        w_index_ok      = (int'(w_index) < NUM_CHAINS);
        w_hdr_last      = (r_hdr_cnt == HCNT_W'(CMD_BITS - 1));
    end

    // One-hot decode of the selected core and its scan-out bit.
    always_comb begin
        w_sel_onehot   = {NUM_CHAINS{1'b0}};
        w_sel_scan_out = 1'b0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            w_sel_onehot[i] = (int'(r_sel) == i);
            w_sel_scan_out  = w_sel_scan_out | (chain_scan_out[i] & (int'(r_sel) == i));
        end
    end

    // State register; busy mirrors the state that is being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // Next-state logic: cs_n high ends any transaction.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!cs_n) w_next_state = S_CMD;
                else       w_next_state = S_IDLE;
            end
            S_CMD: begin
                if (cs_n) begin
                    w_next_state = S_IDLE;
                end else if (w_hdr_last) begin
                    case (w_opcode)
                        2'b00:   w_next_state = w_index_ok ? S_STREAM : S_DISCARD;
                        2'b01:   w_next_state = S_STATUS;
                        2'b10:   w_next_state = S_MASKWR;
                        default: w_next_state = S_DISCARD;
                    endcase
                end else begin
                    w_next_state = S_CMD;
                end
            end
            S_STREAM, S_STATUS, S_MASKWR, S_DISCARD: begin
                if (cs_n) w_next_state = S_IDLE;
                else      w_next_state = r_state;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: header capture, status snapshot, mask write, stream count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hdr        <= {CMD_BITS{1'b0}};
            r_hdr_cnt    <= {HCNT_W{1'b0}};
            r_sel        <= {IDX_W{1'b0}};
            r_stat_sr    <= {NUM_CHAINS{1'b0}};
            r_mask_sr    <= {NUM_CHAINS{1'b0}};
            r_mask_cnt   <= {MCNT_W{1'b0}};
            r_run_mask   <= {NUM_CHAINS{1'b1}};
            r_stream_cnt <= {CNT_W{1'b0}};
        end else if (!cs_n) begin
            case (r_state)
                S_IDLE: begin
                    r_hdr        <= {{(CMD_BITS-1){1'b0}}, mosi};
                    r_hdr_cnt    <= HCNT_W'(1);
                    r_stream_cnt <= {CNT_W{1'b0}};
                end
                S_CMD: begin
                    r_hdr     <= w_hdr_next;
                    r_hdr_cnt <= r_hdr_cnt + HCNT_W'(1);
                    if (w_hdr_last) begin
                        r_sel      <= w_index;
                        r_mask_cnt <= {MCNT_W{1'b0}};
                        if (w_opcode == 2'b01) r_stat_sr <= halt_in;
                    end
                end
                S_STREAM: begin
                    if (r_stream_cnt != {CNT_W{1'b1}}) r_stream_cnt <= r_stream_cnt + CNT_W'(1);
                end
                S_STATUS: begin
                    r_stat_sr <= w_stat_shift;
                end
                S_MASKWR: begin
                    if (int'(r_mask_cnt) < NUM_CHAINS) begin
                        r_mask_sr  <= w_mask_next;
                        r_mask_cnt <= r_mask_cnt + MCNT_W'(1);
                        if (int'(r_mask_cnt) == NUM_CHAINS - 1) r_run_mask <= w_mask_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pin outputs: select path has priority over the processor-run path.
    always_comb begin
        chain_scan_enable = {NUM_CHAINS{1'b0}};
        chain_scan_in     = 1'b0;
        miso              = 1'b0;
        proc_en           = {NUM_CHAINS{1'b0}};
        if (!rst) begin
            chain_scan_enable = {NUM_CHAINS{1'b0}};
        end else begin
            if (r_state == S_STREAM) begin
                chain_scan_enable = w_sel_onehot & {NUM_CHAINS{!cs_n}};
                chain_scan_in     = mosi;
            end else begin
                chain_scan_in     = 1'b0;
            end
            if (!cs_n) begin
                case (r_state)
                    S_STREAM: miso = w_sel_scan_out;
                    S_STATUS: miso = r_stat_sr[NUM_CHAINS-1];
                    default:  miso = 1'b0;
                endcase
            end else if (!proc_en_n) begin
                miso = |(halt_in & r_run_mask);
            end else begin
                miso = 1'b0;
            end
            if (cs_n && !proc_en_n && (r_state == S_IDLE)) proc_en = r_run_mask;
            else                                          proc_en = {NUM_CHAINS{1'b0}};
        end
    end

    assign stream_count = r_stream_cnt;
    assign busy         = r_busy;

endmodule

// File: tb/tb_qtcore_spi_frontend.sv
// Directed bench: a 4-chain/16-bit-counter instance and a 3-chain/4-bit-counter
// instance share the pin stimulus so both configurations are checked together.
module tb_qtcore_spi_frontend;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cs_n, proc_en_n, mosi;
    logic [3:0] cso, halt;

    logic        miso_a, sin_a, busy_a;
    logic [3:0]  en_a, pe_a;
    logic [15:0] cnt_a;
    logic        miso_b, sin_b, busy_b;
    logic [2:0]  en_b, pe_b;
    logic [3:0]  cnt_b;

    qtcore_spi_frontend #(.NUM_CHAINS(4), .CMD_BITS(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .cs_n(cs_n), .proc_en_n(proc_en_n), .mosi(mosi),
        .miso(miso_a), .chain_scan_enable(en_a), .chain_scan_in(sin_a),
        .chain_scan_out(cso), .halt_in(halt), .proc_en(pe_a),
        .stream_count(cnt_a), .busy(busy_a));

    qtcore_spi_frontend #(.NUM_CHAINS(3), .CMD_BITS(4), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .cs_n(cs_n), .proc_en_n(proc_en_n), .mosi(mosi),
        .miso(miso_b), .chain_scan_enable(en_b), .chain_scan_in(sin_b),
        .chain_scan_out(cso[2:0]), .halt_in(halt[2:0]), .proc_en(pe_b),
        .stream_count(cnt_b), .busy(busy_b));

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bit period: inputs change on the falling edge, sample 1 ns later.
    task automatic drive(input logic cs, input logic d);
        @(negedge clk);
        cs_n = cs;
        mosi = d;
        #1;
    endtask

    task automatic send(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, bits[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] data;
        logic [5:0] seq_a, seq_b;

        // Reset: every output must be 0 even with proc_en_n low and cores halted.
        rst = 1'b0; cs_n = 1'b1; proc_en_n = 1'b0; mosi = 1'b0; cso = 4'h0; halt = 4'hF;
        #2;
        check_eq("rst_miso_a", 32'(miso_a), 32'h0);
        check_eq("rst_pe_a",   32'(pe_a),   32'h0);
        check_eq("rst_en_a",   32'(en_a),   32'h0);
        check_eq("rst_busy_a", 32'(busy_a), 32'h0);
        check_eq("rst_cnt_a",  32'(cnt_a),  32'h0);
        check_eq("rst_pe_b",   32'(pe_b),   32'h0);
        @(negedge clk);
        rst = 1'b1; proc_en_n = 1'b1;
        drive(1'b1, 1'b0);
        check_eq("idle_busy", 32'(busy_a), 32'h0);

        // 1: stream chain 1 with 10110010 while chain_scan_out[1] toggles.
        send(8'h01, 4);
        check_eq("t1_hdr_en",   32'(en_a),   32'h0);
        check_eq("t1_hdr_busy", 32'(busy_a), 32'h1);
        data = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cs_n = 1'b0;
            mosi = data[7-i];
            cso  = i[0] ? 4'b0010 : 4'b1101;
            #1;
            check_eq("t1_en_a",   32'(en_a),   32'h2);
            check_eq("t1_sin_a",  32'(sin_a),  32'(data[7-i]));
            check_eq("t1_miso_a", 32'(miso_a), 32'(i[0]));
            check_eq("t1_en_b",   32'(en_b),   32'h2);
            check_eq("t1_miso_b", 32'(miso_b), 32'(i[0]));
        end
        drive(1'b1, 1'b0);
        check_eq("t1_en_drop", 32'(en_a),   32'h0);
        check_eq("t1_busy",    32'(busy_a), 32'h1);
        check_eq("t1_cnt_a",   32'(cnt_a),  32'h8);
        check_eq("t1_cnt_b",   32'(cnt_b),  32'h8);
        drive(1'b1, 1'b0);
        check_eq("t1_idle",    32'(busy_a), 32'h0);
        check_eq("t1_cnt_hold", 32'(cnt_a), 32'h8);

        // 2: status snapshot of 1010; halt_in changes mid-read.
        halt = 4'b1010;
        send(8'h04, 4);
        seq_a = 6'b101000;
        seq_b = 6'b010000;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0);
            check_eq("t2_miso_a", 32'(miso_a), 32'(seq_a[5-i]));
            check_eq("t2_miso_b", 32'(miso_b), 32'(seq_b[5-i]));
            halt = 4'b0101;
        end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);

        // 3: mask write 0110 (small build commits 011), then run with halts.
        send(8'h08, 4);
        send(8'h06, 4);
        proc_en_n = 1'b0;
        halt = 4'b0100;
        drive(1'b1, 1'b0);
        check_eq("t3_miso_end", 32'(miso_a), 32'h1);
        check_eq("t3_pe_notidle", 32'(pe_a), 32'h0);
        drive(1'b1, 1'b0);
        check_eq("t3_pe_a",   32'(pe_a),   32'h6);
        check_eq("t3_miso_a", 32'(miso_a), 32'h1);
        check_eq("t3_pe_b",   32'(pe_b),   32'h3);
        check_eq("t3_miso_b", 32'(miso_b), 32'h0);
        halt = 4'b1001;
        #1;
        check_eq("t3_miso_a2", 32'(miso_a), 32'h0);
        check_eq("t3_miso_b2", 32'(miso_b), 32'h1);
        proc_en_n = 1'b1;

        // 4: restore all-ones mask, then an aborted 2-bit mask write.
        send(8'h08, 4);
        send(8'h0F, 4);
        drive(1'b1, 1'b0);
        send(8'h08, 4);
        send(8'h00, 2);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        proc_en_n = 1'b0;
        #1;
        check_eq("t4_pe_a", 32'(pe_a), 32'hF);
        check_eq("t4_pe_b", 32'(pe_b), 32'h7);
        proc_en_n = 1'b1;
        // Header 0011: chain 3 on the 4-chain build, out of range on the 3-chain build.
        send(8'h03, 4);
        cso = 4'hF;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1);
            check_eq("t4_disc_en_b",   32'(en_b),   32'h0);
            check_eq("t4_disc_miso_b", 32'(miso_b), 32'h0);
            check_eq("t4_disc_busy_b", 32'(busy_b), 32'h1);
            check_eq("t4_ch3_en_a",    32'(en_a),   32'h8);
            check_eq("t4_ch3_miso_a",  32'(miso_a), 32'h1);
        end
        drive(1'b1, 1'b0);
        check_eq("t4_busy_b_last", 32'(busy_b), 32'h1);
        check_eq("t4_en_a_drop",   32'(en_a),   32'h0);
        drive(1'b1, 1'b0);
        check_eq("t4_busy_b_idle", 32'(busy_b), 32'h0);
        // Opcode 11 discards on the 4-chain build too.
        send(8'h0C, 4);
        drive(1'b0, 1'b1);
        check_eq("t4_op3_busy", 32'(busy_a), 32'h1);
        check_eq("t4_op3_en",   32'(en_a),   32'h0);
        check_eq("t4_op3_miso", 32'(miso_a), 32'h0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);

        // 5: set mask 0101, then reset in the middle of a stream.
        send(8'h08, 4);
        send(8'h05, 4);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        proc_en_n = 1'b0;
        #1;
        check_eq("t5_pe_pre", 32'(pe_a), 32'h5);
        proc_en_n = 1'b1;
        send(8'h02, 4);
        send(8'h07, 3);
        @(posedge clk);
        #2;
        check_eq("t5_cnt3", 32'(cnt_a), 32'h3);
        check_eq("t5_en3",  32'(en_a),  32'h4);
        rst = 1'b0;
        #1;
        check_eq("t5_rst_en",   32'(en_a),   32'h0);
        check_eq("t5_rst_busy", 32'(busy_a), 32'h0);
        check_eq("t5_rst_cnt",  32'(cnt_a),  32'h0);
        check_eq("t5_rst_miso", 32'(miso_a), 32'h0);
        cs_n = 1'b1;
        proc_en_n = 1'b0;
        #1;
        check_eq("t5_rst_pe", 32'(pe_a), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t5_mask_a", 32'(pe_a), 32'hF);
        check_eq("t5_mask_b", 32'(pe_b), 32'h7);
        proc_en_n = 1'b1;
        send(8'h01, 4);
        drive(1'b0, 1'b1);
        check_eq("t5_next_en",   32'(en_a),   32'h2);
        check_eq("t5_next_busy", 32'(busy_a), 32'h1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);

        // 6: 20 bits on chain 0 with proc_en_n also low; small counter saturates.
        send(8'h00, 4);
        proc_en_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cs_n = 1'b0;
            mosi = i[1];
            cso  = i[0] ? 4'b0001 : 4'b1110;
            #1;
            if (i < 4) begin
                check_eq("t6_pe_a",   32'(pe_a),   32'h0);
                check_eq("t6_miso_a", 32'(miso_a), 32'(i[0]));
                check_eq("t6_sin_a",  32'(sin_a),  32'(i[1]));
                check_eq("t6_miso_b", 32'(miso_b), 32'(i[0]));
            end
        end
        drive(1'b1, 1'b0);
        check_eq("t6_cnt_a", 32'(cnt_a), 32'h14);
        check_eq("t6_cnt_b", 32'(cnt_b), 32'hF);
        proc_en_n = 1'b1;
        drive(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qtcore_spi_frontend.md
Name: qtcore_spi_frontend

Overview:
- Parametrised SPI-style front end that sits between the chip I/O pins and NUM_CHAINS qtcore accumulator microcontroller instances.
- Each transaction starts with a command header. The header selects one of four operations:
  - stream the scan chain of one selected core;
  - read back a halt-status snapshot of all cores;
  - write a per-core run mask;
  - discard (reserved opcode or out-of-range index).
- Outside a transaction, proc_en_n starts every unmasked core, and miso reports their combined halt status.

Parameters:
- NUM_CHAINS, 4, number of attached cores/scan chains (1..2^(CMD_BITS-2)).
- CMD_BITS, 4, header length in bits. Header fields: opcode[CMD_BITS-1:CMD_BITS-2], index[CMD_BITS-3:0].
- CNT_W, 16, width of the saturating stream bit counter.

Ports:
- clk  in  1  system clock; also the SPI bit clock. All sampling is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cs_n  in  1  scan/transaction select, active low.
- proc_en_n  in  1  processor run request, active low.
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- chain_scan_enable  out  NUM_CHAINS  one-hot scan enable to the cores.
- chain_scan_in  out  1  broadcast scan data to the cores.
- chain_scan_out  in  NUM_CHAINS  per-core scan data out.
- halt_in  in  NUM_CHAINS  per-core halt flags.
- proc_en  out  NUM_CHAINS  per-core processor enable.
- stream_count  out  CNT_W  number of bits streamed in the current/last STREAM transaction.
- busy  out  1  high whenever state != IDLE.

Behaviour:

Reset (rst low, asynchronous):
- state=IDLE, run_mask=all ones, stream_count=0.
- Header, status and mask shift registers clear to 0.
- All outputs are 0 while in reset.

States: IDLE, CMD, STREAM, STATUS, MASKWR, DISCARD.

IDLE:
- cs_n low at a rising edge: the first header bit is captured from mosi; state becomes CMD with hdr_cnt=1; stream_count is cleared to 0.

CMD:
- One header bit per edge, MSB first.
- The edge that captures bit CMD_BITS-1 decodes the header:
  - opcode 00 with index<NUM_CHAINS -> STREAM with sel=index;
  - opcode 00 with index>=NUM_CHAINS -> DISCARD;
  - opcode 01 -> STATUS, and the same edge loads stat_sr with the halt_in snapshot;
  - opcode 10 -> MASKWR with mask_cnt=0;
  - opcode 11 -> DISCARD.

STREAM:
- chain_scan_enable[sel] = !cs_n; all other enables are 0.
- chain_scan_in = mosi (combinational).
- miso = chain_scan_out[sel] (combinational).
- stream_count increments on each edge with cs_n low and saturates at all ones (no wrap).

STATUS:
- miso = stat_sr MSB, so halt_in[NUM_CHAINS-1] comes out first.
- stat_sr shifts left one bit per edge, filling with 0. After NUM_CHAINS bits, miso is 0.

MASKWR:
- mosi bits shift MSB-first into the shadow register.
- The edge capturing the NUM_CHAINS-th bit commits the shadow to run_mask.
- Further bits are ignored; miso=0.

DISCARD:
- miso=0, all enables 0, nothing changes.

Transaction end:
- cs_n high at any edge in any non-IDLE state -> IDLE.
- Scan enables are gated combinationally by !cs_n, so they drop in the same cycle cs_n rises.
- An incomplete header or an incomplete mask write has no effect; run_mask is kept.

Processor control:
- proc_en[i] = cs_n & !proc_en_n & run_mask[i] & (state==IDLE).
- With cs_n high and proc_en_n low, miso = OR of (halt_in & run_mask).

miso priority:
- cs_n low: the active state drives miso as above; CMD drives 0.
- Otherwise proc_en_n low: combined halt status.
- Otherwise 0.
- Select has priority over proc; proc_en is 0 whenever cs_n is low.

Other rules:
- busy is registered from state.
- A header whose CMD_BITS-2 index field cannot hold NUM_CHAINS-1 is illegal. An elaboration-time check flags it.

Test Plan:
1. Reset, then header 0001 and 8 mosi bits 10110010 with chain_scan_out[1] toggling. Required: chain_scan_enable=0010 during exactly the 8 data cycles; chain_scan_in mirrors mosi; miso mirrors chain_scan_out[1]; stream_count=8; enable drops the cycle cs_n rises.
2. halt_in=1010, header 0100, then 6 clocks. Required: miso sequence 1,0,1,0,0,0. Changing halt_in mid-read does not change the output.
3. Header 1000 plus mask bits 0110, cs_n high, proc_en_n low, halt_in=0100. Required: proc_en=0110; miso=1. With halt_in=1001, miso=0.
4. Header 1000 plus only 2 mask bits, then cs_n high. Required: run_mask stays 1111. Header 0011 in a build with NUM_CHAINS=3 -> DISCARD: no enables, miso=0, busy=1 until cs_n high.
5. rst pulsed low mid-STREAM after 3 bits. Required: immediately chain_scan_enable=0, busy=0, stream_count=0, run_mask=1111; the next header decodes normally.
6. CNT_W=4 build, 20 streamed bits. Required: stream_count saturates at 15. With cs_n low and proc_en_n low together, proc_en=0 and miso follows the scan path.
